des_round_sched: RTL and testbench
==================================

Name: des_round_sched

Overview:
- Sequencing controller for the shared DES round datapath (E-expansion, S1–S8 boxes, P-permutation) in the IoT data-filter crypto path.
- Accepts one encrypt or decrypt job at a time and owns the 56-bit C/D key-schedule registers.
- Drives load, round-enable, round index and the per-round rotated key (PC-2 is applied outside this block).
- Time-multiplexes one round datapath across 16 rounds, with optional wait states for a pipelined S-box stage.

Parameters:
- SBOX_LAT, 0, extra wait cycles per round for a registered S-box stage; legal range 0..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  high in IDLE only.
- dec_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- key_cd_in  in  56  post-PC-1 key; [55:28] = C, [27:0] = D; sampled on accept.
- rnd_load  out  1  one-cycle pulse; datapath loads L/R from the IP output.
- rnd_en  out  1  one-cycle pulse; datapath launches one round.
- rnd_idx  out  4  current round, 0..15.
- last_round  out  1  rnd_en && rnd_idx==15; datapath suppresses the L/R swap.
- cd_out  out  56  rotated C||D for the current round.
- out_valid  out  1  result ready; held until out_ready.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset values: state IDLE, start_ready=1, rnd_load=0, rnd_en=0, last_round=0, out_valid=0, rnd_idx=0, cd_out=0, wait counter 0. Reset takes effect immediately, in any state.
- FSM states: IDLE, LOAD, ROUND, WAIT, DONE.
- IDLE:
  - Accept occurs when start_valid && start_ready.
  - Latch dec_mode.
  - Encrypt: cd <= key_cd_in with each 28-bit half rotated left by 1.
  - Decrypt: cd <= key_cd_in unrotated.
  - Next state LOAD.
- LOAD: rnd_load=1 for one cycle; rnd_idx=0; next state ROUND.
- ROUND:
  - rnd_en=1 for one cycle.
  - If SBOX_LAT==0: update cd and advance rnd_idx in the same edge.
  - Else: go to WAIT; cd_out and rnd_idx are held stable throughout WAIT.
- WAIT: count SBOX_LAT cycles, then update cd and advance rnd_idx.
- Round advance:
  - If rnd_idx==15, go to DONE; rnd_idx stays 15 and cd is not rotated.
  - Otherwise rnd_idx+1, then ROUND.
- Shift schedule, for the key used in rounds 1..15 (0-based rnd_idx after increment):
  - Encrypt, rotate left, per half: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, rotate right, per half: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Round 0 key: encrypt = rotl1 of the input; decrypt = input itself (K16).
- Rotation rule: C and D rotate independently within 28 bits; no carry between halves.
- Wrap-around: after round 15 the cumulative rotation is 28 (encrypt) or 27 right plus the initial 0 (decrypt). cd_out is not checked in DONE.
- DONE:
  - out_valid=1, held with all other outputs stable until out_ready.
  - Then IDLE at the next edge; start_ready rises that cycle.
  - A start_valid in the same cycle is not accepted; it waits one cycle.
- Latency: accept edge is cycle 0; rnd_load at cycle 1; rnd_en at cycles 2 + k·(1+SBOX_LAT); out_valid first high at cycle 2 + 16·(1+SBOX_LAT).
- Inputs outside IDLE: start_valid, dec_mode and key_cd_in are ignored.
- Out-of-range SBOX_LAT: values above 3 are a configuration error; a simulation assertion fires at time 0.

Optional Feature:
- Macro: DES_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port abort_ack (1 bit).
  - abort high in LOAD, ROUND, WAIT or DONE forces IDLE at the next edge and pulses abort_ack for one cycle.
  - out_valid is dropped; cd_out and rnd_idx return to 0.
  - abort in IDLE has no effect.
  - abort has priority over out_ready.
- Undefined: both ports are absent; jobs always run to completion.

Test Plan:
- Encrypt, SBOX_LAT=0, key_cd_in=56'h0000000_0000001 -> rnd_load at cycle 1; rnd_en cycles 2..17; D-half of cd_out 0x0000002, 0x0000004, 0x0000010 for rnd_idx 0,1,2; last_round at cycle 17; out_valid at cycle 18.
- Decrypt, same key -> D-half of cd_out 0x0000001, 0x8000000, 0x2000000 for rnd_idx 0,1,2; C-half stays 0.
- SBOX_LAT=2, encrypt -> rnd_en every 3 cycles; cd_out unchanged across each WAIT; out_valid at cycle 50.
- out_ready low for 5 cycles in DONE, with start_valid=1 throughout -> out_valid stays 1, start_ready stays 0, no new rnd_load; release -> IDLE, then accept one cycle later.
- rst_n low during rnd_idx=7 -> all outputs at reset values immediately; a new start after release -> full 16-round sequence, correct keys.
- With DES_SCHED_ABORT_EN, abort at rnd_idx=4 -> abort_ack pulse, IDLE next cycle, no out_valid; the next job completes normally.

Source files
------------

// File: rtl/des_round_sched.sv
// des_round_sched: sequencing controller for a shared DES round datapath.
// Owns the 56-bit C/D key-schedule registers. It issues one load pulse and
// then 16 round pulses, with SBOX_LAT wait cycles after each round pulse.
// It drives the rotated C||D for each round. PC-2 is applied downstream.
// Optional feature macro: DES_SCHED_ABORT_EN. When it is defined, the block
// gains an abort input and an abort_ack output.
module des_round_sched #(
   parameter int SBOX_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic        dec_mode,
   input  logic [55:0] key_cd_in,
   output logic        rnd_load,
   output logic        rnd_en,
   output logic [3:0]  rnd_idx,
   output logic        last_round,
   output logic [55:0] cd_out,
   output logic        out_valid,
`ifdef DES_SCHED_ABORT_EN
   input  logic        abort,
   output logic        abort_ack,
`endif
   input  logic        out_ready
);

   typedef enum logic [2:0] {IDLE, LOAD, ROUND, WAIT, DONE} state_e;

   localparam logic [1:0] WAIT_LAST = (SBOX_LAT > 0) ? 2'(SBOX_LAT - 1) : 2'd0;

   if (SBOX_LAT < 0 || SBOX_LAT > 3) begin : gBadSboxLat
      $error("des_round_sched: SBOX_LAT=%0d outside legal range 0..3", SBOX_LAT);
   end

   state_e      state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  rndIdx_q, rndIdx_d;
   logic        decMode_q, decMode_d;
   logic [1:0]  waitCnt_q, waitCnt_d;
`ifdef DES_SCHED_ABORT_EN
   logic        abortAck_q, abortAck_d;
`endif

   logic [3:0]  nextIdx;
   logic        twoBits;
   logic [55:0] cdAdvanced;
   logic        doAdvance;

   // Rotate one 28-bit half left by 1 or 2 positions.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   // Rotate one 28-bit half right by 1 or 2 positions.
   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   // Shift amount for the upcoming round index: rounds 1, 8 and 15 shift by one.
   always_comb begin
      nextIdx = rndIdx_q + 4'd1;
      twoBits = !((nextIdx == 4'd1) || (nextIdx == 4'd8) || (nextIdx == 4'd15));
      if (decMode_q)
         cdAdvanced = {rotr28(cd_q[55:28], twoBits), rotr28(cd_q[27:0], twoBits)};
      else
         cdAdvanced = {rotl28(cd_q[55:28], twoBits), rotl28(cd_q[27:0], twoBits)};
   end

   // State, key, index and wait-count registers; async active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cd_q      <= '0;
         rndIdx_q  <= '0;
         decMode_q <= 1'b0;
         waitCnt_q <= '0;
`ifdef DES_SCHED_ABORT_EN
         abortAck_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cd_q      <= cd_d;
         rndIdx_q  <= rndIdx_d;
         decMode_q <= decMode_d;
         waitCnt_q <= waitCnt_d;
`ifdef DES_SCHED_ABORT_EN
         abortAck_q <= abortAck_d;
`endif
      end
   end

   // Next-state logic: accept, load, round/wait sequencing, completion handshake.
   always_comb begin
      state_d   = state_q;
      cd_d      = cd_q;
      rndIdx_d  = rndIdx_q;
      decMode_d = decMode_q;
      waitCnt_d = waitCnt_q;
      doAdvance = 1'b0;
`ifdef DES_SCHED_ABORT_EN
      abortAck_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               decMode_d = dec_mode;
               rndIdx_d  = 4'd0;
               cd_d      = dec_mode ? key_cd_in
                                    : {rotl28(key_cd_in[55:28], 1'b0), rotl28(key_cd_in[27:0], 1'b0)};
               state_d   = LOAD;
            end
         end
         LOAD: begin
            rndIdx_d = 4'd0;
            state_d  = ROUND;
         end
         ROUND: begin
            if (SBOX_LAT == 0) begin
               doAdvance = 1'b1;
            end else begin
               waitCnt_d = 2'd0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (waitCnt_q == WAIT_LAST)
               doAdvance = 1'b1;
            else
               waitCnt_d = waitCnt_q + 2'd1;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (doAdvance) begin
         if (rndIdx_q == 4'd15) begin
            state_d = DONE;
         end else begin
            rndIdx_d = nextIdx;
            cd_d     = cdAdvanced;
            state_d  = ROUND;
         end
      end

`ifdef DES_SCHED_ABORT_EN
      if (abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         cd_d       = '0;
         rndIdx_d   = 4'd0;
         waitCnt_d  = 2'd0;
         abortAck_d = 1'b1;
      end
`endif
   end

   assign start_ready = (state_q == IDLE);
   assign rnd_load    = (state_q == LOAD);
   assign rnd_en      = (state_q == ROUND);
   assign last_round  = (state_q == ROUND) && (rndIdx_q == 4'd15);
   assign out_valid   = (state_q == DONE);
   assign rnd_idx     = rndIdx_q;
   assign cd_out      = cd_q;
`ifdef DES_SCHED_ABORT_EN
   assign abort_ack   = abortAck_q;
`endif

endmodule

// File: tb/tb_des_round_sched.sv
// tb_des_round_sched: scoreboard bench for des_round_sched.
// It runs two instances: dut0 with SBOX_LAT=0 and dut1 with SBOX_LAT=2.
// Stimulus pushes expected load/round/done events with their cycle numbers.
// A negedge monitor pops each expected event and compares it with the DUT.
module tb_des_round_sched;

   typedef struct {
      int          kind;   // 0 = load, 1 = round, 2 = done
      int          dut;
      int          cyc;
      int          idx;
      logic [55:0] cd;
      bit          last;
   } rec_t;

   logic        clk;
   logic        rstN;
   logic        startValid [2];
   logic        startReady [2];
   logic        decMode    [2];
   logic [55:0] keyIn      [2];
   logic        rndLoad    [2];
   logic        rndEn      [2];
   logic [3:0]  rndIdx     [2];
   logic        lastRound  [2];
   logic [55:0] cdOut      [2];
   logic        outValid   [2];
   logic        outReady   [2];
`ifdef DES_SCHED_ABORT_EN
   logic        abort      [2];
   logic        abortAck   [2];
`endif

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   rec_t expQ[$];
   logic        prevOv [2];
   logic        busy1;
   logic [55:0] heldCd;
   logic [3:0]  heldIdx;

   des_round_sched #(.SBOX_LAT(0)) dut0 (
      .clk(clk), .rst_n(rstN),
      .start_valid(startValid[0]), .start_ready(startReady[0]),
      .dec_mode(decMode[0]), .key_cd_in(keyIn[0]),
      .rnd_load(rndLoad[0]), .rnd_en(rndEn[0]), .rnd_idx(rndIdx[0]),
      .last_round(lastRound[0]), .cd_out(cdOut[0]), .out_valid(outValid[0]),
`ifdef DES_SCHED_ABORT_EN
      .abort(abort[0]), .abort_ack(abortAck[0]),
`endif
      .out_ready(outReady[0]));

   des_round_sched #(.SBOX_LAT(2)) dut1 (
      .clk(clk), .rst_n(rstN),
      .start_valid(startValid[1]), .start_ready(startReady[1]),
      .dec_mode(decMode[1]), .key_cd_in(keyIn[1]),
      .rnd_load(rndLoad[1]), .rnd_en(rndEn[1]), .rnd_idx(rndIdx[1]),
      .last_round(lastRound[1]), .cd_out(cdOut[1]), .out_valid(outValid[1]),
`ifdef DES_SCHED_ABORT_EN
      .abort(abort[1]), .abort_ack(abortAck[1]),
`endif
      .out_ready(outReady[1]));

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so event timing can be compared.
   always @(posedge clk) cyc <= cyc + 1;

   // Record one comparison and print a FAIL line if the values differ.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Rotate one 28-bit half by n single-bit steps.
   function automatic logic [27:0] rotHalf(input logic [27:0] x, input int n, input bit right);
      logic [27:0] y = x;
      for (int i = 0; i < n; i++)
         y = right ? {y[0], y[27:1]} : {y[26:0], y[27]};
      return y;
   endfunction

   // Reference key for round idx: cumulative shift total from the DES schedule.
   function automatic logic [55:0] expKey(input logic [55:0] key, input bit dec, input int idx);
      int total = dec ? 0 : 1;
      for (int r = 1; r <= idx; r++)
         total += (r == 1 || r == 8 || r == 15) ? 1 : 2;
      if (key == 56'h1 && idx < 3) begin
         // Hand-worked keys for key_cd_in = 1.
         case ({dec, 2'(idx)})
            3'b000:  return 56'h0000000_0000002;
            3'b001:  return 56'h0000000_0000004;
            3'b010:  return 56'h0000000_0000010;
            3'b100:  return 56'h0000000_0000001;
            3'b101:  return 56'h0000000_8000000;
            default: return 56'h0000000_2000000;
         endcase
      end
      return {rotHalf(key[55:28], total, dec), rotHalf(key[27:0], total, dec)};
   endfunction

   // Pop the next expected event and compare it with what the DUT presented.
   task automatic observe(input int d, input int kind, input int idx, input logic [55:0] cd, input bit last);
      rec_t e;
      if (expQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL unexpected_event: dut%0d kind %0d at cycle %0d, required none", d, kind, cyc);
         return;
      end
      e = expQ.pop_front();
      checkOutput($sformatf("event_dut idx%0d", e.idx), 64'(d), 64'(e.dut));
      checkOutput($sformatf("event_kind dut%0d idx%0d", d, e.idx), 64'(kind), 64'(e.kind));
      checkOutput($sformatf("event_cycle dut%0d kind%0d idx%0d", d, kind, e.idx), 64'(cyc), 64'(e.cyc));
      if (kind == 1 && e.kind == 1) begin
         checkOutput($sformatf("rnd_idx dut%0d", d), 64'(idx), 64'(e.idx));
         checkOutput($sformatf("cd_out dut%0d idx%0d", d, e.idx), 64'(cd), 64'(e.cd));
         checkOutput($sformatf("last_round dut%0d idx%0d", d, e.idx), 64'(last), 64'(e.last));
      end
   endtask

   // Monitor: match load/round/done events against the scoreboard, and check that dut1 holds its outputs during WAIT.
   always @(negedge clk) begin
      if (rstN) begin
         for (int d = 0; d < 2; d++) begin
            if (rndLoad[d]) observe(d, 0, 0, '0, 1'b0);
            if (rndEn[d])   observe(d, 1, int'(rndIdx[d]), cdOut[d], lastRound[d]);
            if (outValid[d] && !prevOv[d]) observe(d, 2, 0, '0, 1'b0);
         end
         if (busy1 && !rndEn[1] && !outValid[1] && !rndLoad[1]) begin
            checkOutput("wait_hold_cd", 64'(cdOut[1]), 64'(heldCd));
            checkOutput("wait_hold_idx", 64'(rndIdx[1]), 64'(heldIdx));
         end
         if (rndEn[1]) begin
            busy1   <= 1'b1;
            heldCd  <= cdOut[1];
            heldIdx <= rndIdx[1];
         end else if (outValid[1] || rndLoad[1]) begin
            busy1 <= 1'b0;
         end
      end else begin
         busy1 <= 1'b0;
      end
      prevOv[0] <= outValid[0];
      prevOv[1] <= outValid[1];
   end

   // Offer a job at the current negedge, wait for acceptance, and push its expected events.
   task automatic applyStimulus(input int d, input bit dec, input logic [55:0] key);
      int   lat = (d == 0) ? 0 : 2;
      int   n = 0;
      int   base;
      rec_t r;
      startValid[d] = 1'b1;
      decMode[d]    = dec;
      keyIn[d]      = key;
      while (!startReady[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!startReady[d]) begin
         checkOutput("accept_timeout", 64'(startReady[d]), 64'(1));
         startValid[d] = 1'b0;
         return;
      end
      base = cyc;
      r.dut = d; r.idx = 0; r.cd = '0; r.last = 1'b0;
      r.kind = 0; r.cyc = base + 1;
      expQ.push_back(r);
      for (int k = 0; k < 16; k++) begin
         r.kind = 1;
         r.cyc  = base + 2 + k * (1 + lat);
         r.idx  = k;
         r.cd   = expKey(key, dec, k);
         r.last = (k == 15);
         expQ.push_back(r);
      end
      r.kind = 2; r.cyc = base + 2 + 16 * (1 + lat); r.idx = 0; r.cd = '0; r.last = 1'b0;
      expQ.push_back(r);
      @(negedge clk);
      // Scramble inputs while busy; the DUT must ignore them.
      startValid[d] = 1'b0;
      decMode[d]    = ~dec;
      keyIn[d]      = ~key;
   endtask

   // Wait (bounded) until the DUT is back in IDLE.
   task automatic waitIdle(input int d);
      int n = 0;
      while (!startReady[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!startReady[d]) checkOutput("idle_timeout", 64'(startReady[d]), 64'(1));
   endtask

   // Compare every output of one DUT with its reset value.
   task automatic checkResetOutputs(input int d);
      checkOutput($sformatf("rst_start_ready dut%0d", d), 64'(startReady[d]), 64'(1));
      checkOutput($sformatf("rst_rnd_load dut%0d", d), 64'(rndLoad[d]), 64'(0));
      checkOutput($sformatf("rst_rnd_en dut%0d", d), 64'(rndEn[d]), 64'(0));
      checkOutput($sformatf("rst_last_round dut%0d", d), 64'(lastRound[d]), 64'(0));
      checkOutput($sformatf("rst_out_valid dut%0d", d), 64'(outValid[d]), 64'(0));
      checkOutput($sformatf("rst_rnd_idx dut%0d", d), 64'(rndIdx[d]), 64'(0));
      checkOutput($sformatf("rst_cd_out dut%0d", d), 64'(cdOut[d]), 64'(0));
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int n;
      busy1 = 1'b0;
      rstN  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         startValid[d] = 1'b0;
         decMode[d]    = 1'b0;
         keyIn[d]      = '0;
         outReady[d]   = 1'b1;
         prevOv[d]     = 1'b0;
`ifdef DES_SCHED_ABORT_EN
         abort[d]      = 1'b0;
`endif
      end
      repeat (2) @(negedge clk);
      checkResetOutputs(0);
      checkResetOutputs(1);
      rstN = 1'b1;
      @(negedge clk);

      // Encrypt and then decrypt with key 1 on dut0 (no wait states).
      applyStimulus(0, 1'b0, 56'h0000000_0000001);
      waitIdle(0);
      applyStimulus(0, 1'b1, 56'h0000000_0000001);
      waitIdle(0);

      // Encrypt on dut1, which has two wait cycles per round.
      applyStimulus(1, 1'b0, 56'hF0F0F0F_1234567);
      waitIdle(1);
      applyStimulus(1, 1'b1, 56'h8000001_C000003);
      waitIdle(1);

      // Hold out_ready low in DONE with start_valid high.
      outReady[0] = 1'b0;
      applyStimulus(0, 1'b1, 56'h1234567_89ABCDE);
      n = 0;
      while (!outValid[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_reached", 64'(outValid[0]), 64'(1));
      startValid[0] = 1'b1;
      keyIn[0]      = 56'hDEADBEE_FCAFE12;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("hold_out_valid %0d", i), 64'(outValid[0]), 64'(1));
         checkOutput($sformatf("hold_start_ready %0d", i), 64'(startReady[0]), 64'(0));
      end
      outReady[0] = 1'b1;
      @(negedge clk);
      checkOutput("release_start_ready", 64'(startReady[0]), 64'(1));
      checkOutput("release_out_valid", 64'(outValid[0]), 64'(0));
      applyStimulus(0, 1'b0, 56'hA5A5A5A_5A5A5A5);
      waitIdle(0);

      // Asynchronous reset in the middle of a job, at round 7.
      applyStimulus(0, 1'b0, 56'h8000001_0000001);
      n = 0;
      while (!(rndEn[0] && rndIdx[0] == 4'd7) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached_round7", 64'(rndIdx[0]), 64'(7));
      #1 rstN = 1'b0;
      #1 checkResetOutputs(0);
      expQ.delete();
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      applyStimulus(0, 1'b0, 56'h8000001_0000001);
      waitIdle(0);

`ifdef DES_SCHED_ABORT_EN
      // Abort at round 4, then run a normal job.
      applyStimulus(0, 1'b1, 56'h0F0F0F0_F0F0F0F);
      n = 0;
      while (!(rndEn[0] && rndIdx[0] == 4'd4) && n < 100) begin
         @(negedge clk);
         n++;
      end
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checkOutput("abort_ack", 64'(abortAck[0]), 64'(1));
      checkOutput("abort_start_ready", 64'(startReady[0]), 64'(1));
      checkOutput("abort_out_valid", 64'(outValid[0]), 64'(0));
      checkOutput("abort_rnd_idx", 64'(rndIdx[0]), 64'(0));
      checkOutput("abort_cd_out", 64'(cdOut[0]), 64'(0));
      expQ.delete();
      @(negedge clk);
      checkOutput("abort_ack_pulse", 64'(abortAck[0]), 64'(0));
      applyStimulus(0, 1'b0, 56'h0F0F0F0_F0F0F0F);
      waitIdle(0);
`endif

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
